// File: rtl/seg_serial_ctrl.sv
// rtl/seg_serial_ctrl.sv - shifts a 64-bit segment snapshot MSB-first onto a serial 7-segment chain
// Snapshot is taken at acceptance; seg_dout only moves on the edge that drives seg_clk low.
module seg_serial_ctrl #(
  parameter int CLK_DIV      = 2,
  parameter bit AUTO_REFRESH = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] seg_txt,
  input  logic        start,
  output logic        seg_clk,
  output logic        seg_dout,
  output logic        seg_latch,
  output logic        seg_clrn,
  output logic        busy,
  output logic        done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  state_t        state, state_n;
  logic [63:0]   shreg, shreg_n;
  logic [63:0]   last_txt, last_txt_n;
  logic [5:0]    bit_cnt, bit_cnt_n;
  logic [DW-1:0] div_cnt, div_cnt_n;
  logic          pending, pending_n;
  logic          clk_n, latch_n, busy_n, done_n;
  logic          phase_end, trigger;

  // The head of the shift register is the serial data line.
  assign seg_dout  = shreg[63];
  assign phase_end = (div_cnt == DIV_LAST);
  assign trigger   = !done &&
                     (start || (AUTO_REFRESH && (pending || (seg_txt != last_txt))));

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    last_txt_n = last_txt;
    bit_cnt_n  = bit_cnt;
    div_cnt_n  = div_cnt;
    pending_n  = pending;
    clk_n      = seg_clk;
    latch_n    = seg_latch;
    busy_n     = busy;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        if (trigger) begin
          shreg_n    = seg_txt;
          last_txt_n = seg_txt;
          pending_n  = 1'b0;
          busy_n     = 1'b1;
          clk_n      = 1'b0;
          bit_cnt_n  = '0;
          div_cnt_n  = '0;
          state_n    = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (phase_end) begin
          div_cnt_n = '0;
          clk_n     = 1'b1;
          state_n   = SHIFT_HI;
        end else begin
          div_cnt_n = div_cnt + DW'(1);
        end
      end
      SHIFT_HI: begin
        if (phase_end) begin
          div_cnt_n = '0;
          clk_n     = 1'b0;
          if (bit_cnt == 6'd63) begin
            latch_n = 1'b1;
            state_n = LATCH;
          end else begin
            bit_cnt_n = bit_cnt + 6'd1;
            shreg_n   = {shreg[62:0], 1'b0};
            state_n   = SHIFT_LO;
          end
        end else begin
          div_cnt_n = div_cnt + DW'(1);
        end
      end
      LATCH: begin
        if (phase_end) begin
          div_cnt_n = '0;
          latch_n   = 1'b0;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          state_n   = IDLE;
        end else begin
          div_cnt_n = div_cnt + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      last_txt  <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      pending   <= AUTO_REFRESH;
      seg_clk   <= 1'b0;
      seg_latch <= 1'b0;
      seg_clrn  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      last_txt  <= last_txt_n;
      bit_cnt   <= bit_cnt_n;
      div_cnt   <= div_cnt_n;
      pending   <= pending_n;
      seg_clk   <= clk_n;
      seg_latch <= latch_n;
      seg_clrn  <= 1'b1;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_seg_serial_ctrl.sv
// tb/tb_seg_serial_ctrl.sv - scoreboard bench for seg_serial_ctrl
// Three instances: auto/div2, manual/div1, auto/div3; monitors reassemble each shifted word.
module tb_seg_serial_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_r   [3];
  logic        start_r [3];
  logic [63:0] txt_r   [3];
  logic        sclk_w  [3];
  logic        dout_w  [3];
  logic        latch_w [3];
  logic        clrn_w  [3];
  logic        busy_w  [3];
  logic        done_w  [3];

  int checks = 0;
  int failures = 0;
  logic [63:0] q0[$], q1[$], q2[$];

  seg_serial_ctrl #(.CLK_DIV(2), .AUTO_REFRESH(1'b1)) u_auto (
    .clk(clk), .rst(rst_r[0]), .seg_txt(txt_r[0]), .start(start_r[0]),
    .seg_clk(sclk_w[0]), .seg_dout(dout_w[0]), .seg_latch(latch_w[0]),
    .seg_clrn(clrn_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  seg_serial_ctrl #(.CLK_DIV(1), .AUTO_REFRESH(1'b0)) u_man (
    .clk(clk), .rst(rst_r[1]), .seg_txt(txt_r[1]), .start(start_r[1]),
    .seg_clk(sclk_w[1]), .seg_dout(dout_w[1]), .seg_latch(latch_w[1]),
    .seg_clrn(clrn_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  seg_serial_ctrl #(.CLK_DIV(3), .AUTO_REFRESH(1'b1)) u_tim (
    .clk(clk), .rst(rst_r[2]), .seg_txt(txt_r[2]), .start(start_r[2]),
    .seg_clk(sclk_w[2]), .seg_dout(dout_w[2]), .seg_latch(latch_w[2]),
    .seg_clrn(clrn_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 3);
  endfunction

  task automatic chk_eq(input int i, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h expected=%0h time=%0t", name, i, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int i, input logic [63:0] v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic pop_exp(input int i, output bit ok, output logic [63:0] v);
    ok = 1'b0;
    v  = '0;
    case (i)
      0: if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : ((i == 1) ? q1.size() : q2.size());
  endfunction

  // Samples on the falling clock edge; a transfer is judged when busy drops.
  task automatic monitor(input int i);
    bit pclk = 0, pbusy = 0, platch = 0, pdout = 0, active = 0, ok;
    int bits = 0, blen = 0, llen = 0, hlen = 0, lolen = 0;
    logic [63:0] word = '0, exp;
    forever begin
      @(negedge clk);
      if (rst_r[i]) begin
        if (active) pop_exp(i, ok, exp);
        active = 0; pclk = 0; pbusy = 0; platch = 0; pdout = 0;
      end else begin
        if (busy_w[i] && !pbusy) begin
          active = 1; bits = 0; blen = 0; llen = 0; hlen = 0; lolen = 0; word = '0;
        end
        if (done_w[i] || (pbusy && !busy_w[i]))
          chk_eq(i, "done_at_end", done_w[i], pbusy && !busy_w[i]);
        if (active) begin
          if (busy_w[i]) blen++;
          if (sclk_w[i] && !pclk) begin
            chk_eq(i, "lo_phase_len", lolen, div_of(i));
            chk_eq(i, "latch_before_edge", latch_w[i], 0);
            lolen = 0; hlen = 0;
            word = {word[62:0], dout_w[i]};
            bits++;
          end
          if (sclk_w[i] && pclk) chk_eq(i, "dout_stable_hi", dout_w[i], pdout);
          if (!sclk_w[i] && pclk) chk_eq(i, "hi_phase_len", hlen, div_of(i));
          if (sclk_w[i]) hlen++;
          else if (!latch_w[i] && busy_w[i]) lolen++;
          if (latch_w[i] && !platch) chk_eq(i, "edges_before_latch", bits, 64);
          if (latch_w[i]) llen++;
          if (pbusy && !busy_w[i]) begin
            chk_eq(i, "busy_len", blen, 129 * div_of(i));
            chk_eq(i, "latch_len", llen, div_of(i));
            chk_eq(i, "edge_count", bits, 64);
            pop_exp(i, ok, exp);
            chk_eq(i, "expected_transfer", ok, 1);
            if (ok) chk_eq(i, "shifted_word", word, exp);
            active = 0;
          end
        end
        pclk = sclk_w[i]; pbusy = busy_w[i]; platch = latch_w[i]; pdout = dout_w[i];
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_done(input int i, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk);
      #2;
      if (done_w[i]) break;
    end
    chk_eq(i, "done_seen", k < budget, 1);
  endtask

  task automatic wait_rises(input int i, input int n, input int budget);
    bit p;
    int cnt, k;
    p = sclk_w[i];
    cnt = 0;
    for (k = 0; k < budget && cnt < n; k++) begin
      @(posedge clk);
      #2;
      if (sclk_w[i] && !p) cnt++;
      p = sclk_w[i];
    end
    chk_eq(i, "rises_seen", cnt, n);
  endtask

  task automatic pulse_start(input int i);
    start_r[i] = 1'b1;
    cyc(1);
    start_r[i] = 1'b0;
  endtask

  task automatic seq_auto();
    txt_r[0] = 64'hFFFF_0000_A5A5_0F0F;
    push_exp(0, 64'hFFFF_0000_A5A5_0F0F);
    rst_r[0] = 1'b0;
    wait_done(0, 1000);
    cyc(30);
    txt_r[0] = 64'h0;
    push_exp(0, 64'h0);
    wait_rises(0, 10, 1000);
    txt_r[0] = 64'h1234_5678_9ABC_DEF0;
    push_exp(0, 64'h1234_5678_9ABC_DEF0);
    pulse_start(0);
    wait_rises(0, 30, 1000);
    pulse_start(0);
    wait_done(0, 1000);
    wait_done(0, 1000);
    cyc(30);
    txt_r[0] = 64'hDEAD_BEEF_0123_4567;
    push_exp(0, 64'hDEAD_BEEF_0123_4567);
    wait_rises(0, 30, 1000);
    rst_r[0] = 1'b1;
    #1;
    chk_eq(0, "abort_clrn", clrn_w[0], 0);
    chk_eq(0, "abort_sclk", sclk_w[0], 0);
    chk_eq(0, "abort_busy", busy_w[0], 0);
    chk_eq(0, "abort_latch", latch_w[0], 0);
    #1;
    cyc(3);
    push_exp(0, 64'hDEAD_BEEF_0123_4567);
    rst_r[0] = 1'b0;
    cyc(1);
    chk_eq(0, "clrn_after_release", clrn_w[0], 1);
    wait_done(0, 1000);
    cyc(30);
  endtask

  task automatic seq_man();
    txt_r[1] = 64'h8000_0000_0000_0001;
    rst_r[1] = 1'b0;
    cyc(20);
    push_exp(1, 64'h8000_0000_0000_0001);
    pulse_start(1);
    wait_done(1, 500);
    cyc(5);
    txt_r[1] = 64'h0000_0000_0000_000F;
    cyc(20);
  endtask

  task automatic seq_tim();
    txt_r[2] = 64'h0123_4567_89AB_CDEF;
    push_exp(2, 64'h0123_4567_89AB_CDEF);
    rst_r[2] = 1'b0;
    wait_done(2, 2000);
    cyc(10);
    txt_r[2] = 64'hF0F0_1234_5678_0F0F;
    push_exp(2, 64'hF0F0_1234_5678_0F0F);
    pulse_start(2);
    wait_done(2, 2000);
    cyc(30);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_r[i]   = 1'b1;
      start_r[i] = 1'b0;
      txt_r[i]   = '0;
    end
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
    cyc(2);
    for (int i = 0; i < 3; i++) begin
      chk_eq(i, "rst_sclk", sclk_w[i], 0);
      chk_eq(i, "rst_dout", dout_w[i], 0);
      chk_eq(i, "rst_latch", latch_w[i], 0);
      chk_eq(i, "rst_busy", busy_w[i], 0);
      chk_eq(i, "rst_done", done_w[i], 0);
      chk_eq(i, "rst_clrn", clrn_w[i], 0);
    end
    fork
      seq_auto();
      seq_man();
      seq_tim();
    join
    for (int i = 0; i < 3; i++) chk_eq(i, "queue_drained", qsize(i), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
